// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer: FSM encoding, field widths
// and the branch-offset helper.
package pc_fetch_sequencer_pkg;

   localparam int INSTR_W   = 32;
   localparam int JTARGET_W = 26;
   localparam int IMM_W     = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      HOLD   = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

   // Word offset to byte offset, sign-extended to a full address.
   function automatic logic [31:0] branch_offset(input logic [IMM_W-1:0] imm);
      return {{14{imm[IMM_W-1]}}, imm, 2'b00};
   endfunction

endpackage

// File: rtl/pc_fetch_sequencer_next_pc_calc.sv
// Combinational next-PC selection: sequential, branch, jump or jump-register,
// plus detection of a misaligned jump-register target.
module next_pc_calc
   import pc_fetch_sequencer_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0]    pc,
   input  logic                 branch_taken,
   input  logic [IMM_W-1:0]     branch_imm,
   input  logic                 jump,
   input  logic [JTARGET_W-1:0] jump_target,
   input  logic                 jump_reg,
   input  logic [ADDR_W-1:0]    jr_addr,
   output logic [ADDR_W-1:0]    pc_plus4,
   output logic [ADDR_W-1:0]    next_pc,
   output logic                 misalign
);

   assign pc_plus4 = pc + ADDR_W'(4);

   // Redirect priority: jump_reg > jump > branch_taken > sequential.
   always_comb begin
      next_pc  = pc_plus4;
      misalign = 1'b0;
      if (jump_reg) begin
         next_pc  = {jr_addr[ADDR_W-1:2], 2'b00};
         misalign = |jr_addr[1:0];
      end else if (jump) begin
         next_pc = {pc_plus4[ADDR_W-1:ADDR_W-4], jump_target, 2'b00};
      end else if (branch_taken) begin
         next_pc = pc_plus4 + branch_offset(branch_imm);
      end
   end

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program-counter owner: issues instruction-memory fetches, holds each word until
// decode accepts it, then advances PC sequentially or to a redirect target.
module pc_fetch_sequencer
   import pc_fetch_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          ADDR_W       = 32
) (
   input  logic                 clock,
   input  logic                 reset_n,
   output logic                 imem_req,
   output logic [ADDR_W-1:0]    imem_addr,
   input  logic                 imem_ack,
   input  logic [INSTR_W-1:0]   imem_rdata,
   output logic [INSTR_W-1:0]   instr,
   output logic                 instr_valid,
   input  logic                 instr_ready,
   output logic [ADDR_W-1:0]    pc,
   output logic [ADDR_W-1:0]    pc_plus4,
   input  logic                 branch_taken,
   input  logic [IMM_W-1:0]     branch_imm,
   input  logic                 jump,
   input  logic [JTARGET_W-1:0] jump_target,
   input  logic                 jump_reg,
   input  logic [ADDR_W-1:0]    jr_addr,
   input  logic                 halt,
   output logic                 misalign_err,
   output logic [31:0]          instr_count
);

   fetch_state_t        state_reg, state_next;
   logic [ADDR_W-1:0]   pc_reg;
   logic [INSTR_W-1:0]  instr_reg;
   logic                instr_valid_reg;
   logic                imem_req_reg;
   logic                misalign_reg;
   logic [31:0]         count_reg;
   logic [ADDR_W-1:0]   next_pc;
   logic                misalign;
   logic                fetch_ack;
   logic                transfer;

   next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc_calc (
      .pc           (pc_reg),
      .branch_taken (branch_taken),
      .branch_imm   (branch_imm),
      .jump         (jump),
      .jump_target  (jump_target),
      .jump_reg     (jump_reg),
      .jr_addr      (jr_addr),
      .pc_plus4     (pc_plus4),
      .next_pc      (next_pc),
      .misalign     (misalign)
   );

   assign fetch_ack = (state_reg == FETCH) && imem_ack;
   assign transfer  = (state_reg == HOLD) && instr_ready;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    state_next = halt ? HALTED : FETCH;
         FETCH:   if (imem_ack) state_next = HOLD;
         HOLD:    if (instr_ready) state_next = halt ? HALTED : FETCH;
         HALTED:  state_next = HALTED;
         default: state_next = IDLE;
      endcase
   end

   // Request/valid flags are derived from the next state so they stay registered
   // yet line up exactly with the state they describe.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_reg       <= IDLE;
         pc_reg          <= RESET_VECTOR[ADDR_W-1:0];
         instr_reg       <= '0;
         instr_valid_reg <= 1'b0;
         imem_req_reg    <= 1'b0;
         misalign_reg    <= 1'b0;
         count_reg       <= '0;
      end else begin
         state_reg       <= state_next;
         imem_req_reg    <= (state_next == FETCH);
         instr_valid_reg <= (state_next == HOLD);
         misalign_reg    <= transfer && misalign;
         if (fetch_ack) begin
            instr_reg <= imem_rdata;
         end
         if (transfer) begin
            pc_reg    <= next_pc;
            count_reg <= count_reg + 32'd1;
         end
      end
   end

   assign imem_req     = imem_req_reg;
   assign imem_addr    = pc_reg;
   assign pc           = pc_reg;
   assign instr        = instr_reg;
   assign instr_valid  = instr_valid_reg;
   assign misalign_err = misalign_reg;
   assign instr_count  = count_reg;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench with a transfer scoreboard; a second instance with a wrapping
// reset vector runs in lockstep on the same inputs.
module tb_pc_fetch_sequencer;

   logic        clock;
   logic        reset_n;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        instr_ready;
   logic        branch_taken;
   logic [15:0] branch_imm;
   logic        jump;
   logic [25:0] jump_target;
   logic        jump_reg;
   logic [31:0] jr_addr;
   logic        halt;

   logic        imem_req, instr_valid, misalign_err;
   logic [31:0] imem_addr, instr, pc, pc_plus4, instr_count;

   logic        w_imem_req, w_instr_valid, w_misalign_err;
   logic [31:0] w_imem_addr, w_instr, w_pc, w_pc_plus4, w_instr_count;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } txn_t;

   txn_t sb_q[$];
   int   n_vec = 0;
   int   n_err = 0;

   pc_fetch_sequencer dut (
      .clock(clock), .reset_n(reset_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .pc(pc), .pc_plus4(pc_plus4),
      .branch_taken(branch_taken), .branch_imm(branch_imm),
      .jump(jump), .jump_target(jump_target), .jump_reg(jump_reg), .jr_addr(jr_addr),
      .halt(halt), .misalign_err(misalign_err), .instr_count(instr_count)
   );

   pc_fetch_sequencer #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
      .clock(clock), .reset_n(reset_n),
      .imem_req(w_imem_req), .imem_addr(w_imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(w_instr), .instr_valid(w_instr_valid), .instr_ready(instr_ready),
      .pc(w_pc), .pc_plus4(w_pc_plus4),
      .branch_taken(branch_taken), .branch_imm(branch_imm),
      .jump(jump), .jump_target(jump_target), .jump_reg(jump_reg), .jr_addr(jr_addr),
      .halt(halt), .misalign_err(w_misalign_err), .instr_count(w_instr_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Monitor: every accepted instruction must match the oldest scoreboard entry.
   always @(negedge clock) begin
      txn_t t;
      if (reset_n && instr_valid && instr_ready) begin
         if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_transfer: got pc %h instr %h required no transfer", pc, instr);
         end else begin
            t = sb_q.pop_front();
            check("xfer_pc", pc, t.addr);
            check("xfer_instr", instr, t.data);
            $display("txn pc=%h instr=%h count=%0d", pc, instr, instr_count);
         end
      end
   end

   task automatic clear_redirects();
      branch_taken = 1'b0; branch_imm = 16'h0; jump = 1'b0; jump_target = 26'h0;
      jump_reg = 1'b0; jr_addr = 32'h0; halt = 1'b0;
   endtask

   task automatic wait_req(input string name);
      int i;
      i = 0;
      while (!imem_req && i < 50) begin
         @(posedge clock); #1;
         i++;
      end
      check(name, {31'h0, imem_req}, 32'h1);
   endtask

   // One fetch: ack at exp_addr, optional stall with garbage redirects, then accept.
   task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] data, input int stall,
                        input logic br, input logic [15:0] imm, input logic jp,
                        input logic [25:0] jt, input logic jr, input logic [31:0] jra,
                        input logic hlt);
      txn_t t;
      wait_req("req_timeout");
      check("imem_addr", imem_addr, exp_addr);
      imem_ack = 1'b1;
      imem_rdata = data;
      t.addr = exp_addr;
      t.data = data;
      sb_q.push_back(t);
      @(posedge clock); #1;
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
      check("valid_after_ack", {31'h0, instr_valid}, 32'h1);
      for (int s = 0; s < stall; s++) begin
         branch_taken = 1'b1; jump = 1'b1; jump_reg = 1'b1; halt = 1'b1; jr_addr = 32'hBAD0_0001;
         imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA;
         @(posedge clock); #1;
         imem_ack = 1'b0;
         check("stall_instr", instr, data);
         check("stall_req", {31'h0, imem_req}, 32'h0);
         check("stall_pc", pc, exp_addr);
      end
      clear_redirects();
      branch_taken = br; branch_imm = imm; jump = jp; jump_target = jt;
      jump_reg = jr; jr_addr = jra; halt = hlt;
      instr_ready = 1'b1;
      @(posedge clock); #1;
      instr_ready = 1'b0;
      clear_redirects();
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
      clear_redirects();
      repeat (3) @(posedge clock);
      #1;
      check("rst_req", {31'h0, imem_req}, 32'h0);
      check("rst_valid", {31'h0, instr_valid}, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_pc", pc, 32'h0);
      check("rst_pc_plus4", pc_plus4, 32'h4);
      check("rst_count", instr_count, 32'h0);
      check("rst_misalign", {31'h0, misalign_err}, 32'h0);
      check("wrap_rst_pc", w_pc, 32'hFFFF_FFFC);
      check("wrap_pc_plus4", w_pc_plus4, 32'h0);
      reset_n = 1'b1;

      // Sequential run
      fetch(32'h0, 32'hA000_0000, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
      check("wrap_second_addr", w_imem_addr, 32'h0);
      fetch(32'h4, 32'hA000_0004, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
      fetch(32'h8, 32'hA000_0008, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
      fetch(32'hC, 32'hA000_000C, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
      check("count_after_4", instr_count, 32'd4);

      // Backpressure: redirects, halt and acks during the stall must be ignored
      fetch(32'h10, 32'hB000_0010, 5, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
      check("bp_no_misalign", {31'h0, misalign_err}, 32'h0);
      check("bp_count", instr_count, 32'd5);

      // Jump beats branch: 0x14 -> 0x100
      fetch(32'h14, 32'hC000_0014, 0, 1, 16'hFFFE, 1, 26'h0000040, 0, 32'h0, 0);
      check("jump_pc", pc, 32'h100);
      // Backward branch: 0x100 + 4 - 8 = 0xFC
      fetch(32'h100, 32'hC000_0100, 0, 1, 16'hFFFE, 0, 26'h0, 0, 32'h0, 0);
      check("branch_pc", pc, 32'hFC);
      check("branch_no_misalign", {31'h0, misalign_err}, 32'h0);
      // JR beats everything, misaligned target
      fetch(32'hFC, 32'hC000_00FC, 0, 1, 16'h0010, 1, 26'h0000123, 1, 32'h0000_2003, 0);
      check("jr_pc", pc, 32'h2000);
      check("jr_misalign_pulse", {31'h0, misalign_err}, 32'h1);
      @(posedge clock); #1;
      check("jr_misalign_clear", {31'h0, misalign_err}, 32'h0);

      // Halt with accept, then stray acks and halt=0 must not resume
      fetch(32'h2000, 32'hD000_2000, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1);
      for (int c = 0; c < 20; c++) begin
         imem_ack = c[0];
         imem_rdata = 32'hEEEE_0000 | 32'(c);
         @(posedge clock); #1;
         check("halt_req", {31'h0, imem_req}, 32'h0);
      end
      imem_ack = 1'b0;
      check("halt_valid", {31'h0, instr_valid}, 32'h0);
      check("halt_pc", pc, 32'h2004);
      check("halt_count", instr_count, 32'd9);

      // Reset mid-fetch with a late ack
      reset_n = 1'b0;
      @(posedge clock); #1;
      reset_n = 1'b1;
      fetch(32'h0, 32'hE000_0000, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
      wait_req("midfetch_req_timeout");
      check("midfetch_addr", imem_addr, 32'h4);
      reset_n = 1'b0;
      imem_ack = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;
      @(posedge clock); #1;
      reset_n = 1'b1;
      check("mid_rst_pc", pc, 32'h0);
      check("mid_rst_req", {31'h0, imem_req}, 32'h0);
      check("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
      check("mid_rst_count", instr_count, 32'h0);
      @(posedge clock); #1;
      imem_ack = 1'b0;
      imem_rdata = 32'h0;
      check("late_ack_valid", {31'h0, instr_valid}, 32'h0);
      check("late_ack_instr", instr, 32'h0);
      check("fresh_req", {31'h0, imem_req}, 32'h1);
      fetch(32'h0, 32'h1234_5678, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0);
      check("fresh_count", instr_count, 32'd1);

      @(posedge clock); #1;
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
